// File: rtl/im2_responder.sv
// im2_responder: IM2 interrupt-acknowledge responder that drives the vector byte and snoops RETI.
// Define IM2RESP_RETI_EN to enable in-service tracking and nested priority masking.
module im2_responder #(
  parameter int         NSRC        = 4,
  parameter logic [7:0] VECTOR_BASE = 8'hF0
) (
  input  logic            clk28,
  input  logic            rst_n,
  input  logic            clkcpu_ck,
  input  logic            bus_m1,
  input  logic            bus_iorq,
  input  logic            bus_rd,
  input  logic [7:0]      bus_d_in,
  input  logic [NSRC-1:0] req,
  output logic            n_int_ext,
  output logic            vector_oe,
  output logic [7:0]      vector,
  output logic [NSRC-1:0] ack,
  output logic [NSRC-1:0] in_service
);
  typedef enum logic {ACK_IDLE, ACK_DRIVE} ack_t;
  ack_t r_ack_st, w_ack_nx;
  logic [NSRC-1:0] r_req_q, r_pend, w_rise, w_elig, w_take, w_lo;
  logic [2:0] w_idx;
  logic r_inta_q, w_inta, w_start;
  assign w_inta = bus_m1 & bus_iorq;
  assign w_rise = req & ~r_req_q;
  // Lowest set in_service bit is the active level; only lower indices may interrupt it.
  assign w_lo   = in_service & (~in_service + NSRC'(1));
  assign w_elig = r_pend & (w_lo - NSRC'(1));
  assign w_start = (r_ack_st == ACK_IDLE) & w_inta & ~r_inta_q & (|w_elig);
  always_comb begin
    w_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (w_elig[i]) w_idx = 3'(i);
  end
  assign w_take = w_start ? (NSRC'(1) << w_idx) : '0;
  always_comb w_ack_nx = (r_ack_st == ACK_IDLE) ? (w_start ? ACK_DRIVE : ACK_IDLE) : (w_inta ? ACK_DRIVE : ACK_IDLE);
  always_ff @(posedge clk28) begin
    if (!rst_n) r_ack_st <= ACK_IDLE;
    else r_ack_st <= w_ack_nx;
  end
  assign vector_oe = (r_ack_st == ACK_DRIVE);
  // Tracks req through reset so a level held across reset is not a new request.
  always_ff @(posedge clk28) r_req_q <= req;
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_inta_q  <= 1'b0;
      n_int_ext <= 1'b1;
      vector    <= VECTOR_BASE;
      ack       <= '0;
    end else begin
      r_pend   <= (r_pend & ~w_take) | w_rise;
      r_inta_q <= w_inta;
      ack      <= w_take;
      if (clkcpu_ck) n_int_ext <= ~|w_elig;
      if (w_start) vector <= VECTOR_BASE | {4'b0000, w_idx, 1'b0};
    end
  end
`ifdef IM2RESP_RETI_EN
  typedef enum logic {R_IDLE, R_ED} reti_t;
  reti_t r_reti_st, w_reti_nx;
  logic r_fetch_q, w_fetch, w_end, w_rel;
  logic [7:0] r_op;
  logic [NSRC-1:0] r_isv;
  assign w_fetch = bus_m1 & bus_rd & ~bus_iorq;
  assign w_end   = r_fetch_q & ~w_fetch;
  always_comb begin
    w_reti_nx = r_reti_st;
    w_rel     = 1'b0;
    if (w_end) begin
      w_reti_nx = (r_op == 8'hED) ? R_ED : R_IDLE;
      w_rel     = (r_reti_st == R_ED) & (r_op == 8'h4D);
    end
  end
  always_ff @(posedge clk28) begin
    if (!rst_n) r_reti_st <= R_IDLE;
    else r_reti_st <= w_reti_nx;
  end
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_fetch_q <= 1'b0;
      r_isv     <= '0;
    end else begin
      r_fetch_q <= w_fetch;
      r_isv     <= (r_isv & ~(w_rel ? w_lo : '0)) | w_take;
    end
  end
  // Last byte seen during the fetch is the opcode.
  always_ff @(posedge clk28) if (w_fetch) r_op <= bus_d_in;
  assign in_service = r_isv;
`else
  logic w_unused;
  assign w_unused   = ^{bus_rd, bus_d_in};
  assign in_service = '0;
`endif
endmodule

// File: tb/tb_im2_responder.sv
// tb_im2_responder: directed stimulus with an ack/vector scoreboard for im2_responder.
module tb_im2_responder;
`ifdef IM2RESP_RETI_EN
  localparam bit RETI = 1'b1;
`else
  localparam bit RETI = 1'b0;
`endif
  logic clk28 = 0, rst_n = 0, clkcpu_ck = 0, bus_m1 = 0, bus_iorq = 0, bus_rd = 0;
  logic [7:0] bus_d_in = 0;
  logic [3:0] req = 0;
  logic n_int_ext, vector_oe;
  logic [7:0] vector;
  logic [3:0] ack, in_service;
  int tests = 0, fails = 0;
  logic [11:0] sbq[$];

  im2_responder #(.NSRC(4), .VECTOR_BASE(8'hF0)) dut (
    .clk28(clk28), .rst_n(rst_n), .clkcpu_ck(clkcpu_ck), .bus_m1(bus_m1), .bus_iorq(bus_iorq),
    .bus_rd(bus_rd), .bus_d_in(bus_d_in), .req(req), .n_int_ext(n_int_ext), .vector_oe(vector_oe),
    .vector(vector), .ack(ack), .in_service(in_service)
  );

  always #5 clk28 = ~clk28;

  initial begin
    int n = 0;
    forever begin
      @(negedge clk28);
      n++;
      clkcpu_ck = (n % 4 == 0);
    end
  end

  always @(negedge clk28) begin
    if (ack !== 4'b0) begin
      logic [11:0] exp;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL ack_unexpected ack=%b vector=%h", ack, vector);
      end else begin
        exp = sbq.pop_front();
        if ({vector_oe, ack, vector} !== {1'b1, exp}) begin
          fails++;
          $display("FAIL ack_vector got oe=%b ack=%b vec=%h want oe=1 ack=%b vec=%h",
                   vector_oe, ack, vector, exp[11:8], exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic inta(input string name, input bit exp_oe);
    bus_m1 = 1; bus_iorq = 1;
    cyc(3);
    check({name, "_oe_hi"}, vector_oe, exp_oe);
    bus_m1 = 0; bus_iorq = 0;
    cyc(1);
    check({name, "_oe_lo"}, vector_oe, 1'b0);
    cyc(2);
  endtask

  task automatic fetch(input logic [7:0] b, input bit m1);
    bus_m1 = m1; bus_rd = 1; bus_d_in = b;
    cyc(2);
    bus_m1 = 0; bus_rd = 0; bus_d_in = 8'h00;
    cyc(2);
  endtask

  task automatic reti();
    fetch(8'hED, 1);
    fetch(8'h4D, 1);
  endtask

  initial begin
    cyc(3);
    check("rst_nint", n_int_ext, 1'b1);
    check("rst_oe", vector_oe, 1'b0);
    check("rst_vector", vector, 8'hF0);
    check("rst_ack", ack, 4'b0);
    check("rst_isv", in_service, 4'b0);
    rst_n = 1;
    cyc(2);
    // Empty INTA: no response expected
    inta("empty", 1'b0);
    check("empty_nint", n_int_ext, 1'b1);
    // Single source
    req = 4'b0100;
    cyc(6);
    check("single_nint_lo", n_int_ext, 1'b0);
    sbq.push_back({4'b0100, 8'hF4});
    inta("single", 1'b1);
    cyc(6);
    check("single_nint_hi", n_int_ext, 1'b1);
    check("single_isv", in_service, RETI ? 4'b0100 : 4'b0);
    reti();
    check("single_isv_rel", in_service, 4'b0);
    req = 0;
    cyc(2);
    // Priority: 3 and 1 together
    req = 4'b1010;
    cyc(6);
    check("prio_nint_lo", n_int_ext, 1'b0);
    sbq.push_back({4'b0010, 8'hF2});
    inta("prio1", 1'b1);
    cyc(6);
    check("prio_masked", n_int_ext, RETI);
    check("prio_isv", in_service, RETI ? 4'b0010 : 4'b0);
    reti();
    cyc(6);
    check("prio_nint_again", n_int_ext, 1'b0);
    sbq.push_back({4'b1000, 8'hF6});
    inta("prio2", 1'b1);
    check("prio_isv2", in_service, RETI ? 4'b1000 : 4'b0);
    reti();
    check("prio_isv2_rel", in_service, 4'b0);
    req = 0;
    cyc(2);
    // Nesting
    req = 4'b0100;
    cyc(6);
    sbq.push_back({4'b0100, 8'hF4});
    inta("nest2", 1'b1);
    req = 4'b1100;
    cyc(6);
    check("nest_low_masked", n_int_ext, RETI);
    req = 4'b1101;
    cyc(6);
    check("nest_hi_nint", n_int_ext, 1'b0);
    sbq.push_back({4'b0001, 8'hF0});
    inta("nest0", 1'b1);
    check("nest_isv", in_service, RETI ? 4'b0101 : 4'b0);
    reti();
    check("nest_isv_rel0", in_service, RETI ? 4'b0100 : 4'b0);
    cyc(6);
    check("nest_still_masked", n_int_ext, RETI);
    reti();
    check("nest_isv_rel2", in_service, 4'b0);
    cyc(6);
    check("nest_nint3", n_int_ext, 1'b0);
    sbq.push_back({4'b1000, 8'hF6});
    inta("nest3", 1'b1);
    reti();
    check("nest_isv_clear", in_service, 4'b0);
    req = 0;
    cyc(2);
    // RETI decode variants
    req = 4'b0010;
    cyc(6);
    sbq.push_back({4'b0010, 8'hF2});
    inta("dec", 1'b1);
    fetch(8'hED, 1);
    fetch(8'h45, 1);
    check("dec_retn", in_service, RETI ? 4'b0010 : 4'b0);
    fetch(8'hED, 0);
    fetch(8'h4D, 1);
    check("dec_non_m1", in_service, RETI ? 4'b0010 : 4'b0);
    fetch(8'hED, 1);
    fetch(8'hED, 1);
    fetch(8'h4D, 1);
    check("dec_ed_ed_4d", in_service, 4'b0);
    req = 0;
    cyc(2);
    // Reset during vector drive
    req = 4'b0100;
    cyc(6);
    sbq.push_back({4'b0100, 8'hF4});
    bus_m1 = 1; bus_iorq = 1;
    cyc(3);
    check("rstmid_oe_hi", vector_oe, 1'b1);
    rst_n = 0;
    cyc(1);
    check("rstmid_oe", vector_oe, 1'b0);
    check("rstmid_isv", in_service, 4'b0);
    check("rstmid_nint", n_int_ext, 1'b1);
    bus_m1 = 0; bus_iorq = 0;
    cyc(2);
    rst_n = 1;
    cyc(8);
    check("rstmid_pend_clr", n_int_ext, 1'b1);
    check("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
